// File: rtl/qsram_access_controller_if.sv
// Host request/response and QSRAM strobe/data signals between the bus-side
// logic (master) and the access controller (slave).
interface qsram_access_controller_if #(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  HostReq;
    logic                  HostWrite;
    logic [ADDR_WIDTH-1:0] HostAddr;
    logic [DATA_WIDTH-1:0] HostWData;
    logic                  HostReady;
    logic [DATA_WIDTH-1:0] HostRData;
    logic                  HostRValid;
    logic [ADDR_WIDTH-1:0] MemAddress;
    logic                  MemEnable;
    logic                  MemRead;
    logic                  MemWrite;
    logic                  MemRefresh;
    logic [DATA_WIDTH-1:0] MemWData;
    logic                  MemDataOe;
    logic [DATA_WIDTH-1:0] MemRData;
    logic                  RefreshOverrun;

    modport master (
        output HostReq, HostWrite, HostAddr, HostWData, MemRData,
        input  HostReady, HostRData, HostRValid,
        input  MemAddress, MemEnable, MemRead, MemWrite, MemRefresh,
        input  MemWData, MemDataOe, RefreshOverrun
    );

    modport slave (
        input  HostReq, HostWrite, HostAddr, HostWData, MemRData,
        output HostReady, HostRData, HostRValid,
        output MemAddress, MemEnable, MemRead, MemWrite, MemRefresh,
        output MemWData, MemDataOe, RefreshOverrun
    );
endinterface

// File: rtl/qsram_access_controller.sv
// Sequences single-word host reads/writes and periodic row refreshes onto one
// SDR QSRAM macro; refresh takes priority over host traffic at IDLE.
module qsram_access_controller #(
    parameter int unsigned ADDR_WIDTH       = 4,
    parameter int unsigned DATA_WIDTH       = 8,
    parameter int unsigned READ_CYCLES      = 2,
    parameter int unsigned WRITE_CYCLES     = 1,
    parameter int unsigned REFRESH_CYCLES   = 2,
    parameter int unsigned REFRESH_INTERVAL = 64
) (
    input  logic Clock,
    input  logic Reset,
    qsram_access_controller_if.slave bus
);

    localparam int unsigned MAX_RW  = (READ_CYCLES > WRITE_CYCLES) ? READ_CYCLES : WRITE_CYCLES;
    localparam int unsigned MAX_CYC = (MAX_RW > REFRESH_CYCLES) ? MAX_RW : REFRESH_CYCLES;
    localparam int unsigned CW      = $clog2(MAX_CYC) + 1;
    localparam int unsigned TW      = $clog2(REFRESH_INTERVAL) + 1;

    typedef enum logic [1:0] {IDLE, RD, WR, RF} state_t;

    state_t                state;
    logic [CW-1:0]         cnt;
    logic [TW-1:0]         timer;
    logic                  refresh_pending;
    logic [ADDR_WIDTH-1:0] row;
    logic                  ready;
    logic                  timer_expired;

    assign ready         = (state == IDLE) && !refresh_pending;
    assign bus.HostReady = ready;
    assign timer_expired = (timer == '0);

    // Refresh timer, pending flag and sticky overrun.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            timer              <= TW'(REFRESH_INTERVAL - 1);
            refresh_pending    <= 1'b0;
            bus.RefreshOverrun <= 1'b0;
        end else begin
            if (timer_expired) begin
                timer <= TW'(REFRESH_INTERVAL - 1);
                if (refresh_pending) begin
                    bus.RefreshOverrun <= 1'b1;
                end
            end else begin
                timer <= timer - 1'b1;
            end

            if (timer_expired) begin
                refresh_pending <= 1'b1;
            end else if (state == IDLE && refresh_pending) begin
                refresh_pending <= 1'b0;
            end
        end
    end

    // Operation sequencer; strobes are loaded on entry and cleared on exit so
    // that MemAddress/MemWData simply hold their last value while idle.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state          <= IDLE;
            cnt            <= '0;
            row            <= '0;
            bus.MemAddress <= '0;
            bus.MemEnable  <= 1'b0;
            bus.MemRead    <= 1'b0;
            bus.MemWrite   <= 1'b0;
            bus.MemRefresh <= 1'b0;
            bus.MemWData   <= '0;
            bus.MemDataOe  <= 1'b0;
            bus.HostRData  <= '0;
            bus.HostRValid <= 1'b0;
        end else begin
            bus.HostRValid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (refresh_pending) begin
                        state          <= RF;
                        cnt            <= CW'(REFRESH_CYCLES - 1);
                        bus.MemEnable  <= 1'b1;
                        bus.MemRefresh <= 1'b1;
                        bus.MemAddress <= row;
                    end else if (bus.HostReq && ready) begin
                        bus.MemEnable  <= 1'b1;
                        bus.MemAddress <= bus.HostAddr;
                        if (bus.HostWrite) begin
                            state         <= WR;
                            cnt           <= CW'(WRITE_CYCLES - 1);
                            bus.MemWrite  <= 1'b1;
                            bus.MemDataOe <= 1'b1;
                            bus.MemWData  <= bus.HostWData;
                        end else begin
                            state       <= RD;
                            cnt         <= CW'(READ_CYCLES - 1);
                            bus.MemRead <= 1'b1;
                        end
                    end
                end
                RD: begin
                    if (cnt == '0) begin
                        state          <= IDLE;
                        bus.MemEnable  <= 1'b0;
                        bus.MemRead    <= 1'b0;
                        bus.HostRData  <= bus.MemRData;
                        bus.HostRValid <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                WR: begin
                    if (cnt == '0) begin
                        state         <= IDLE;
                        bus.MemEnable <= 1'b0;
                        bus.MemWrite  <= 1'b0;
                        bus.MemDataOe <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RF: begin
                    if (cnt == '0) begin
                        state          <= IDLE;
                        bus.MemEnable  <= 1'b0;
                        bus.MemRefresh <= 1'b0;
                        row            <= row + 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_qsram_access_controller.sv
// Directed bench for qsram_access_controller: access timing, refresh cadence
// and priority, reset mid-read, read-back against a reference array, overrun.
module tb_qsram_access_controller;

    localparam int unsigned AW = 4;
    localparam int unsigned DW = 8;

    logic Clock  = 1'b0;
    logic Reset  = 1'b1;
    logic Reset2 = 1'b1;
    always #5 Clock = ~Clock;

    qsram_access_controller_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
    qsram_access_controller_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) sbus ();

    qsram_access_controller #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_CYCLES(2), .WRITE_CYCLES(1),
        .REFRESH_CYCLES(2), .REFRESH_INTERVAL(64)
    ) dut (.Clock(Clock), .Reset(Reset), .bus(bus));

    qsram_access_controller #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_CYCLES(40), .WRITE_CYCLES(1),
        .REFRESH_CYCLES(2), .REFRESH_INTERVAL(20)
    ) dut_stress (.Clock(Clock), .Reset(Reset2), .bus(sbus));

    // QSRAM behavioural array for the main instance
    logic [DW-1:0] mem [16];
    logic [DW-1:0] refm [16];
    always @(posedge Clock) begin
        if (Reset) begin
            for (int i = 0; i < 16; i++) mem[i] <= '0;
        end else if (bus.MemEnable && bus.MemWrite && bus.MemDataOe) begin
            mem[bus.MemAddress] <= bus.MemWData;
        end
    end
    assign bus.MemRData  = bus.MemRead ? mem[bus.MemAddress] : '0;
    assign sbus.MemRData = 8'h3C;

    int unsigned cyc = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    int unsigned viol = 0;
    int unsigned hrv_count = 0;
    always @(negedge Clock) begin
        if (!Reset) begin
            if (int'(bus.MemRead) + int'(bus.MemWrite) + int'(bus.MemRefresh) > 1) viol++;
            if (bus.MemDataOe && !bus.MemWrite) viol++;
            if ((bus.MemRead || bus.MemWrite || bus.MemRefresh) && !bus.MemEnable) viol++;
            if (bus.HostRValid) hrv_count++;
        end
    end

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Called at a negedge; returns at the negedge of cycle T+1.
    task automatic start_op(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int unsigned k = 0;
        while (!bus.HostReady && k < 200) begin
            @(negedge Clock);
            k++;
        end
        if (!bus.HostReady) check("ready_timeout", 32'(bus.HostReady), 1);
        bus.HostReq   = 1'b1;
        bus.HostWrite = wr;
        bus.HostAddr  = a;
        bus.HostWData = d;
        @(negedge Clock);
        bus.HostReq = 1'b0;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        start_op(1'b1, a, d);
        refm[a] = d;
        @(negedge Clock);
    endtask

    task automatic do_read(input string tag, input logic [AW-1:0] a);
        int unsigned n = 1;
        start_op(1'b0, a, '0);
        while (!bus.HostRValid && n < 100) begin
            @(negedge Clock);
            n++;
        end
        check({tag, "_lat"}, n, 3);
        check({tag, "_data"}, 32'(bus.HostRData), 32'(refm[a]));
        @(negedge Clock);
    endtask

    task automatic wait_refresh_rise();
        int unsigned n = 0;
        while (!bus.MemRefresh && n < 200) begin
            @(negedge Clock);
            n++;
        end
        if (!bus.MemRefresh) check("refresh_timeout", 32'(bus.MemRefresh), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned rel, last, hv0, e;
        bus.HostReq = 0; bus.HostWrite = 0; bus.HostAddr = '0; bus.HostWData = '0;
        sbus.HostReq = 0; sbus.HostWrite = 0; sbus.HostAddr = '0; sbus.HostWData = '0;
        for (int i = 0; i < 16; i++) refm[i] = '0;

        // Reset state
        repeat (3) @(negedge Clock);
        check("rst_enable", 32'(bus.MemEnable), 0);
        check("rst_strobes", {bus.MemRead, bus.MemWrite, bus.MemRefresh, bus.MemDataOe}, 0);
        check("rst_addr", 32'(bus.MemAddress), 0);
        check("rst_rvalid", 32'(bus.HostRValid), 0);
        check("rst_rdata", 32'(bus.HostRData), 0);
        check("rst_overrun", 32'(bus.RefreshOverrun), 0);
        Reset = 1'b0;
        rel = cyc;
        @(negedge Clock);

        // Write 0xA5 to addr 3, then read it back
        start_op(1'b1, 4'd3, 8'hA5);
        refm[3] = 8'hA5;
        check("wr_strobe", {bus.MemEnable, bus.MemWrite, bus.MemDataOe, bus.MemRead}, 4'b1110);
        check("wr_addr", 32'(bus.MemAddress), 3);
        check("wr_data", 32'(bus.MemWData), 32'hA5);
        @(negedge Clock);
        check("wr_end", {bus.MemEnable, bus.MemWrite, bus.MemDataOe}, 0);
        check("idle_addr_hold", 32'(bus.MemAddress), 3);
        start_op(1'b0, 4'd3, '0);
        check("rd_c1", {bus.MemEnable, bus.MemRead, bus.MemWrite}, 3'b110);
        check("rd_addr", 32'(bus.MemAddress), 3);
        @(negedge Clock);
        check("rd_c2", {bus.MemRead, bus.HostRValid}, 2'b10);
        @(negedge Clock);
        check("rd_c3", {bus.MemRead, bus.HostRValid}, 2'b01);
        check("rd_data", 32'(bus.HostRData), 32'hA5);
        @(negedge Clock);
        check("rd_pulse_end", 32'(bus.HostRValid), 0);

        // Refresh cadence and row wrap: 17 refreshes, rows 0..15 then 0
        last = 0;
        for (int k = 0; k < 17; k++) begin
            wait_refresh_rise();
            check("rf_row", 32'(bus.MemAddress), 32'(k % 16));
            // pending sets 64 clocks after release, RF is entered one clock later
            if (k == 0) check("rf_first", cyc - rel, 65);
            else        check("rf_period", cyc - last, 64);
            last = cyc;
            @(negedge Clock);
            check("rf_c2", {bus.MemEnable, bus.MemRefresh}, 2'b11);
            @(negedge Clock);
            check("rf_end", {bus.MemEnable, bus.MemRefresh}, 0);
        end

        // Request arriving in the cycle the refresh becomes pending
        repeat (61) @(negedge Clock);
        bus.HostReq = 1'b1; bus.HostWrite = 1'b0; bus.HostAddr = 4'd3;
        check("prio_ready_low", 32'(bus.HostReady), 0);
        @(negedge Clock);
        check("prio_rf_first", {bus.MemRefresh, bus.MemRead, bus.HostReady}, 3'b100);
        check("prio_rf_row", 32'(bus.MemAddress), 1);
        @(negedge Clock);
        check("prio_rf_c2", 32'(bus.MemRefresh), 1);
        @(negedge Clock);
        check("prio_idle_ready", {bus.HostReady, bus.MemRefresh}, 2'b10);
        @(negedge Clock);
        bus.HostReq = 1'b0;
        check("prio_rd", {bus.MemRead, bus.MemAddress}, {1'b1, 4'd3});
        repeat (2) @(negedge Clock);
        check("prio_rvalid", {bus.HostRValid, bus.HostRData}, {1'b1, 8'hA5});
        @(negedge Clock);

        // Read/write mix against the reference array, spanning several refreshes
        do_write(4'd0, 8'h11);
        do_write(4'd15, 8'hF0);
        do_read("mix_r0", 4'd0);
        do_read("mix_r15", 4'd15);
        do_read("mix_unwritten", 4'd9);
        do_write(4'd15, 8'h0F);
        do_read("mix_r15b", 4'd15);
        for (int i = 0; i < 32; i++) do_write(4'(i % 16), 8'(i * 7 + 1));
        for (int i = 0; i < 16; i++) do_read("sweep", 4'(i));

        // Reset asserted during a read
        @(negedge Clock);
        start_op(1'b0, 4'd5, '0);
        check("rst_rd_active", 32'(bus.MemRead), 1);
        hv0 = hrv_count;
        #2 Reset = 1'b1;
        #1;
        check("rst_async_strobes", {bus.MemEnable, bus.MemRead, bus.MemWrite, bus.MemRefresh, bus.MemDataOe}, 0);
        check("rst_async_addr", 32'(bus.MemAddress), 0);
        repeat (2) @(negedge Clock);
        Reset = 1'b0;
        rel = cyc;
        for (int i = 0; i < 16; i++) refm[i] = '0;
        wait_refresh_rise();
        check("rst_rf_delay", cyc - rel, 65);
        check("rst_rf_row", 32'(bus.MemAddress), 0);
        check("rst_no_rvalid", hrv_count - hv0, 0);
        repeat (3) @(negedge Clock);
        do_read("post_rst", 4'd3);

        check("strobe_rules", viol, 0);

        // Read longer than two refresh intervals
        @(negedge Clock);
        Reset2 = 1'b0;
        check("ovr_init", {sbus.RefreshOverrun, sbus.HostReady}, 2'b01);
        sbus.HostReq = 1'b1; sbus.HostWrite = 1'b0; sbus.HostAddr = 4'd2;
        @(negedge Clock);
        sbus.HostReq = 1'b0;
        e = 1;
        check("ovr_rd", 32'(sbus.MemRead), 1);
        repeat (28) @(negedge Clock);
        e += 28;
        check("ovr_mid", {sbus.RefreshOverrun, sbus.HostReady, sbus.MemRead}, 3'b001);
        while (!sbus.HostRValid && e < 120) begin
            @(negedge Clock);
            e++;
        end
        check("ovr_rd_lat", e, 41);
        check("ovr_rdata", 32'(sbus.HostRData), 32'h3C);
        check("ovr_set", 32'(sbus.RefreshOverrun), 1);
        repeat (60) @(negedge Clock);
        check("ovr_sticky", 32'(sbus.RefreshOverrun), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
